// File: rtl/pmp_region_programmer_pkg.sv
// Shared RISC-V PMP types: address-matching mode, pmpcfg byte layout and
// the programmer FSM state encoding.
package pmp_region_programmer_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_addr_mode_t;

  // One pmpcfg byte, MSB first: L, reserved, A, X, W, R.
  typedef struct packed {
    logic           l;
    logic [1:0]     rsvd;
    pmp_addr_mode_t a;
    logic           x;
    logic           w;
    logic           r;
  } pmpcfg_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CFG_OFF,
    CFG_OFF_PREV,
    ADDR_PREV,
    ADDR,
    CFG,
    RESP
  } state_t;

endpackage

// File: rtl/pmp_region_programmer_if.sv
// Request / CSR-write / response bundle between a PMP region requester and
// the programmer. The master modport is the requester plus CSR-file side.
interface pmp_region_programmer_if #(
  parameter int PLEN       = 56,
  parameter int PMP_LEN    = 54,
  parameter int NR_ENTRIES = 16
);
  localparam int IDX_W = $clog2(NR_ENTRIES);

  logic               req_valid_i;
  logic               req_ready_o;
  logic [PLEN-1:0]    req_base_i;
  logic [5:0]         req_size_i;
  logic [IDX_W-1:0]   req_idx_i;
  logic [2:0]         req_perm_i;
  logic               req_lock_i;

  logic               wr_valid_o;
  logic               wr_ready_i;
  logic               wr_is_cfg_o;
  logic [IDX_W-1:0]   wr_idx_o;
  logic [PMP_LEN-1:0] wr_data_o;

  logic               rsp_valid_o;
  logic               rsp_err_o;

  modport master (
    output req_valid_i, req_base_i, req_size_i, req_idx_i, req_perm_i, req_lock_i,
    output wr_ready_i,
    input  req_ready_o, wr_valid_o, wr_is_cfg_o, wr_idx_o, wr_data_o,
    input  rsp_valid_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_base_i, req_size_i, req_idx_i, req_perm_i, req_lock_i,
    input  wr_ready_i,
    output req_ready_o, wr_valid_o, wr_is_cfg_o, wr_idx_o, wr_data_o,
    output rsp_valid_o, rsp_err_o
  );
endinterface

// File: rtl/pmp_region_programmer_encode.sv
// Pure combinational region encoder: picks the PMP matching mode, derives
// the pmpaddr values and flags requests that cannot be programmed.
module pmp_region_encode
  import pmp_region_programmer_pkg::*;
#(
  parameter  int PLEN       = 56,
  parameter  int PMP_LEN    = 54,
  parameter  int NR_ENTRIES = 16,
  localparam int IDX_W      = $clog2(NR_ENTRIES)
) (
  input  logic [PLEN-1:0]       base,
  input  logic [5:0]            size,
  input  logic [IDX_W-1:0]      idx,
  input  logic [NR_ENTRIES-1:0] locked,
  output pmp_addr_mode_t        mode,
  output logic [PMP_LEN-1:0]    addr,
  output logic [PMP_LEN-1:0]    addr_prev,
  output logic                  err
);

  localparam logic [PLEN:0] ONE = {{PLEN{1'b0}}, 1'b1};

  // All arithmetic runs at PLEN+1 bits so a region ending exactly at 2^PLEN
  // is representable.
  logic [PLEN:0]    span;
  logic [PLEN:0]    mask;
  logic [PLEN:0]    end_addr;
  logic             aligned;
  logic             size_bad;
  logic             range_bad;
  logic             tor_bad;
  logic [IDX_W-1:0] prev_idx;

  always_comb begin
    span      = ONE << size;
    mask      = span - ONE;
    end_addr  = {1'b0, base} + span;
    aligned   = (base & mask[PLEN-1:0]) == '0;
    prev_idx  = idx - IDX_W'(1);

    if (size == 6'd2)                  mode = NA4;
    else if (size >= 6'd3 && aligned)  mode = NAPOT;
    else                               mode = TOR;

    size_bad  = (size < 6'd2) || (int'(size) > PLEN);
    range_bad = end_addr > {1'b1, {PLEN{1'b0}}};
    tor_bad   = (mode == TOR) && ((idx == '0) || locked[prev_idx]);
    err       = size_bad || range_bad || locked[idx] || tor_bad;

    addr_prev = PMP_LEN'(base >> 2);
    case (mode)
      NAPOT:   addr = PMP_LEN'(base >> 2) | PMP_LEN'(mask >> 3);
      TOR:     addr = PMP_LEN'(end_addr >> 2);
      default: addr = PMP_LEN'(base >> 2);
    endcase
  end

endmodule

// File: rtl/pmp_region_programmer.sv
// Turns a (base, log2 size, perms) region request into the ordered pmpcfg /
// pmpaddr CSR writes, disabling the entry first so no half-written rule is live.
module pmp_region_programmer
  import pmp_region_programmer_pkg::*;
#(
  parameter int PLEN       = 56,
  parameter int PMP_LEN    = 54,
  parameter int NR_ENTRIES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NR_ENTRIES-1:0] locked_i,
  pmp_region_programmer_if.slave bus
);

  localparam int IDX_W = $clog2(NR_ENTRIES);

  state_t             state_q, state_d;
  logic [PLEN-1:0]    base_q;
  logic [5:0]         size_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   prev_idx;
  logic [2:0]         perm_q;
  logic               lock_q;
  logic               err_q;

  pmp_addr_mode_t     enc_mode;
  logic [PMP_LEN-1:0] enc_addr;
  logic [PMP_LEN-1:0] enc_addr_prev;
  logic               enc_err;
  pmpcfg_t            cfg;

  pmp_region_encode #(
    .PLEN       (PLEN),
    .PMP_LEN    (PMP_LEN),
    .NR_ENTRIES (NR_ENTRIES)
  ) u_encode (
    .base      (base_q),
    .size      (size_q),
    .idx       (idx_q),
    .locked    (locked_i),
    .mode      (enc_mode),
    .addr      (enc_addr),
    .addr_prev (enc_addr_prev),
    .err       (enc_err)
  );

  assign prev_idx = idx_q - IDX_W'(1);
  assign cfg      = '{l: lock_q, rsvd: 2'b00, a: enc_mode,
                      x: perm_q[2], w: perm_q[1], r: perm_q[0]};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: these registers carry no reset; each is loaded before any state
  // that reads it can be reached.
  always_ff @(posedge clk_i) begin
    if (bus.req_valid_i && bus.req_ready_o) begin
      base_q <= bus.req_base_i;
      size_q <= bus.req_size_i;
      idx_q  <= bus.req_idx_i;
      perm_q <= bus.req_perm_i;
      lock_q <= bus.req_lock_i;
    end
    // locked_i only matters here; later changes cannot abort the sequence.
    if (state_q == CHECK) err_q <= enc_err;
  end

  // NOTE: every output and the next state get a default first so no path
  // through the case infers a latch.
  always_comb begin
    state_d         = state_q;
    bus.req_ready_o = 1'b0;
    bus.wr_valid_o  = 1'b0;
    bus.wr_is_cfg_o = 1'b0;
    bus.wr_idx_o    = '0;
    bus.wr_data_o   = '0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_err_o   = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready_o = !rst_i;
        if (bus.req_valid_i && !rst_i) state_d = CHECK;
      end
      CHECK: state_d = enc_err ? RESP : CFG_OFF;
      CFG_OFF: begin
        bus.wr_valid_o  = 1'b1;
        bus.wr_is_cfg_o = 1'b1;
        bus.wr_idx_o    = idx_q;
        if (bus.wr_ready_i) state_d = (enc_mode == TOR) ? CFG_OFF_PREV : ADDR;
      end
      CFG_OFF_PREV: begin
        bus.wr_valid_o  = 1'b1;
        bus.wr_is_cfg_o = 1'b1;
        bus.wr_idx_o    = prev_idx;
        if (bus.wr_ready_i) state_d = ADDR_PREV;
      end
      ADDR_PREV: begin
        bus.wr_valid_o = 1'b1;
        bus.wr_idx_o   = prev_idx;
        bus.wr_data_o  = enc_addr_prev;
        if (bus.wr_ready_i) state_d = ADDR;
      end
      ADDR: begin
        bus.wr_valid_o = 1'b1;
        bus.wr_idx_o   = idx_q;
        bus.wr_data_o  = enc_addr;
        if (bus.wr_ready_i) state_d = CFG;
      end
      CFG: begin
        bus.wr_valid_o  = 1'b1;
        bus.wr_is_cfg_o = 1'b1;
        bus.wr_idx_o    = idx_q;
        bus.wr_data_o   = {{(PMP_LEN-8){1'b0}}, cfg};
        if (bus.wr_ready_i) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = err_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmp_region_programmer.sv
// Directed bench for pmp_region_programmer: hand-computed CSR write streams
// for NA4/NAPOT/TOR, rejections, back-pressure and mid-sequence reset.
module tb_pmp_region_programmer;

  localparam int PLEN       = 56;
  localparam int PMP_LEN    = 54;
  localparam int NR_ENTRIES = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NR_ENTRIES-1:0] locked = '0;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int wr_count  = 0;
  int check_cyc = 0;
  int rsp_cyc   = 0;

  pmp_region_programmer_if #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR_ENTRIES)) bus ();

  pmp_region_programmer #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR_ENTRIES)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .locked_i (locked),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (bus.wr_valid_o && bus.wr_ready_i) wr_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input string tag, input logic [PLEN-1:0] base, input logic [5:0] size,
                          input logic [3:0] idx, input logic [2:0] perm, input logic lock);
    @(negedge clk);
    check({tag, "_req_ready"}, 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_base_i  = base;
    bus.req_size_i  = size;
    bus.req_idx_i   = idx;
    bus.req_perm_i  = perm;
    bus.req_lock_i  = lock;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check_cyc       = cyc;
  endtask

  task automatic expect_write(input string tag, input logic is_cfg, input logic [3:0] idx,
                              input logic [PMP_LEN-1:0] data);
    int n = 0;
    @(negedge clk);
    while (!bus.wr_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wr_valid"},  64'(bus.wr_valid_o),  64'd1);
    check({tag, "_wr_is_cfg"}, 64'(bus.wr_is_cfg_o), 64'(is_cfg));
    check({tag, "_wr_idx"},    64'(bus.wr_idx_o),    64'(idx));
    check({tag, "_wr_data"},   64'(bus.wr_data_o),   64'(data));
  endtask

  task automatic expect_rsp(input string tag, input logic err);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd1);
    check({tag, "_rsp_err"},   64'(bus.rsp_err_o),   64'(err));
    rsp_cyc = cyc;
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, 64'(bus.rsp_valid_o), 64'd0);
    check({tag, "_back_idle"},     64'(bus.req_ready_o), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag, input logic ready);
    check({tag, "_req_ready"}, 64'(bus.req_ready_o), 64'(ready));
    check({tag, "_wr_valid"},  64'(bus.wr_valid_o),  64'd0);
    check({tag, "_wr_is_cfg"}, 64'(bus.wr_is_cfg_o), 64'd0);
    check({tag, "_wr_idx"},    64'(bus.wr_idx_o),    64'd0);
    check({tag, "_wr_data"},   64'(bus.wr_data_o),   64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
    check({tag, "_rsp_err"},   64'(bus.rsp_err_o),   64'd0);
  endtask

  initial begin
    int w0;
    logic [PMP_LEN-1:0] held_data;
    logic [3:0]         held_idx;

    bus.req_valid_i = 1'b0;
    bus.req_base_i  = '0;
    bus.req_size_i  = '0;
    bus.req_idx_i   = '0;
    bus.req_perm_i  = '0;
    bus.req_lock_i  = 1'b0;
    bus.wr_ready_i  = 1'b1;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b0);
    rst = 1'b0;

    // NAPOT 4 KiB at 0x8000_0000, entry 1; also the 5-cycle latency.
    w0 = wr_count;
    send_req("napot", 56'h8000_0000, 6'd12, 4'd1, 3'b011, 1'b0);
    expect_write("napot_off",  1'b1, 4'd1, 54'h0);
    expect_write("napot_addr", 1'b0, 4'd1, 54'h2000_01FF);
    expect_write("napot_cfg",  1'b1, 4'd1, 54'h1B);
    expect_rsp("napot", 1'b0);
    check("napot_latency", 64'(rsp_cyc - check_cyc + 1), 64'd5);
    check("napot_wr_count", 64'(wr_count - w0), 64'd3);

    // NA4 with lock; locked_i rising after CHECK must not abort.
    send_req("na4", 56'h1000, 6'd2, 4'd0, 3'b001, 1'b1);
    expect_write("na4_off", 1'b1, 4'd0, 54'h0);
    locked[0] = 1'b1;
    expect_write("na4_addr", 1'b0, 4'd0, 54'h400);
    expect_write("na4_cfg",  1'b1, 4'd0, 54'h91);
    expect_rsp("na4", 1'b0);
    locked[0] = 1'b0;

    // TOR: 0x1100 is not 4 KiB aligned.
    w0 = wr_count;
    send_req("tor", 56'h1100, 6'd12, 4'd3, 3'b111, 1'b0);
    expect_write("tor_off",       1'b1, 4'd3, 54'h0);
    expect_write("tor_off_prev",  1'b1, 4'd2, 54'h0);
    expect_write("tor_addr_prev", 1'b0, 4'd2, 54'h440);
    expect_write("tor_addr",      1'b0, 4'd3, 54'h840);
    expect_write("tor_cfg",       1'b1, 4'd3, 54'h0F);
    expect_rsp("tor", 1'b0);
    check("tor_wr_count", 64'(wr_count - w0), 64'd5);

    // NAPOT ending exactly at 2^PLEN is legal.
    send_req("top", 56'hFF_FFFF_FFFF_F000, 6'd12, 4'd4, 3'b101, 1'b0);
    expect_write("top_off",  1'b1, 4'd4, 54'h0);
    expect_write("top_addr", 1'b0, 4'd4, 54'h3F_FFFF_FFFF_FDFF);
    expect_write("top_cfg",  1'b1, 4'd4, 54'h1D);
    expect_rsp("top", 1'b0);

    // Rejections: locked target, TOR at entry 0, TOR with locked previous
    // entry, size too small, region past 2^PLEN. None may write.
    locked[5] = 1'b1;
    w0 = wr_count;
    send_req("err_locked", 56'h2000, 6'd12, 4'd5, 3'b011, 1'b0);
    expect_rsp("err_locked", 1'b1);
    send_req("err_tor0", 56'h1100, 6'd12, 4'd0, 3'b011, 1'b0);
    expect_rsp("err_tor0", 1'b1);
    send_req("err_prev_locked", 56'h1100, 6'd12, 4'd6, 3'b011, 1'b0);
    expect_rsp("err_prev_locked", 1'b1);
    send_req("err_small", 56'h1000, 6'd1, 4'd2, 3'b011, 1'b0);
    expect_rsp("err_small", 1'b1);
    send_req("err_range", 56'hFF_FFFF_FFFF_F000, 6'd13, 4'd2, 3'b011, 1'b0);
    expect_rsp("err_range", 1'b1);
    check("err_no_writes", 64'(wr_count - w0), 64'd0);
    locked[5] = 1'b0;

    // Back-pressure: wr_ready_i low for 7 cycles while in ADDR.
    send_req("stall", 56'h8000_0000, 6'd12, 4'd9, 3'b011, 1'b0);
    expect_write("stall_off", 1'b1, 4'd9, 54'h0);
    @(posedge clk);
    #1 bus.wr_ready_i = 1'b0;
    expect_write("stall_addr", 1'b0, 4'd9, 54'h2000_01FF);
    held_data = bus.wr_data_o;
    held_idx  = bus.wr_idx_o;
    w0        = wr_count;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.wr_valid_o),  64'd1);
      check("stall_data",  64'(bus.wr_data_o),   64'(held_data));
      check("stall_idx",   64'(bus.wr_idx_o),    64'(held_idx));
      check("stall_ready", 64'(bus.req_ready_o), 64'd0);
    end
    check("stall_no_handshake", 64'(wr_count - w0), 64'd0);
    bus.wr_ready_i = 1'b1;
    expect_write("stall_cfg", 1'b1, 4'd9, 54'h1B);
    expect_rsp("stall", 1'b0);

    // Reset during ADDR_PREV abandons the request silently.
    send_req("rst", 56'h1100, 6'd12, 4'd7, 3'b111, 1'b0);
    expect_write("rst_off",       1'b1, 4'd7, 54'h0);
    expect_write("rst_off_prev",  1'b1, 4'd6, 54'h0);
    expect_write("rst_addr_prev", 1'b0, 4'd6, 54'h440);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_ready",  64'(bus.req_ready_o), 64'd1);
    send_req("after_rst", 56'h8000_0000, 6'd12, 4'd1, 3'b011, 1'b0);
    expect_write("after_rst_off",  1'b1, 4'd1, 54'h0);
    expect_write("after_rst_addr", 1'b0, 4'd1, 54'h2000_01FF);
    expect_write("after_rst_cfg",  1'b1, 4'd1, 54'h1B);
    expect_rsp("after_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmp_region_programmer.md
PMP_REGION_PROGRAMMER -- requirements
Module: pmp_region_programmer

Interface
REQ-001 SHALL have parameter PLEN, default 56, physical address width.
REQ-002 SHALL have parameter PMP_LEN, default 54, pmpaddr register width.
REQ-003 SHALL have parameter NR_ENTRIES, default 16, number of PMP entries.
REQ-004 SHALL have ports: clk_i  in  1  clock; one clock, reset is synchronous and active-high, rst_i  in  1  reset.
REQ-005 SHALL have ports: req_valid_i  in  1 / req_ready_o  out  1  request handshake.
REQ-006 SHALL have ports: req_base_i  in  PLEN  region base byte address; req_size_i  in  6  log2 region bytes.
REQ-007 SHALL have ports: req_idx_i  in  $clog2(NR_ENTRIES)  target entry; req_perm_i  in  3  {X,W,R}; req_lock_i  in  1  set L bit.
REQ-008 SHALL have port: locked_i  in  NR_ENTRIES  current L bit per entry.
REQ-009 SHALL have ports: wr_valid_o  out  1 / wr_ready_i  in  1  CSR write handshake; wr_is_cfg_o  out  1  (1 = pmpcfg byte, 0 = pmpaddr).
REQ-010 SHALL have ports: wr_idx_o  out  $clog2(NR_ENTRIES)  entry; wr_data_o  out  PMP_LEN  write data (cfg byte in [7:0], upper bits zero).
REQ-011 SHALL have ports: rsp_valid_o  out  1  one-cycle completion pulse; rsp_err_o  out  1  request rejected, qualified by rsp_valid_o.

Function
REQ-012 SHALL use FSM states IDLE, CHECK, CFG_OFF, CFG_OFF_PREV, ADDR_PREV, ADDR, CFG, RESP.
REQ-013 SHALL assert req_ready_o only in IDLE; an accepted request's fields are registered, and the FSM moves to CHECK.
REQ-014 CHECK SHALL select a mode: NA4 if size==2; NAPOT if size>=3 and base[size-1:0]==0; otherwise TOR.
REQ-015 CHECK SHALL flag an error if size<2, size>PLEN, base+2^size > 2^PLEN, locked_i[idx], or (TOR and (idx==0 or locked_i[idx-1])).
REQ-016 On error, SHALL go to RESP with rsp_err_o=1 and SHALL issue no writes.
REQ-017 The write sequence SHALL be: NA4/NAPOT: CFG_OFF(idx), ADDR(idx), CFG(idx); TOR: CFG_OFF(idx), CFG_OFF_PREV(idx-1), ADDR_PREV(idx-1), ADDR(idx), CFG(idx).
REQ-018 CFG_OFF/CFG_OFF_PREV SHALL write cfg data 0x00.
REQ-019 NA4 ADDR data SHALL be base>>2. NAPOT ADDR data SHALL be (base>>2) | (2^(size-3)-1), with bit size-3 equal to 0.
REQ-020 TOR ADDR_PREV data SHALL be base>>2. TOR ADDR data SHALL be (base+2^size)>>2, computed at PLEN+1 bits.
REQ-021 CFG data SHALL be {req_lock_i, 2'b00, A[1:0], X, W, R}, with A encoded OFF=0, TOR=1, NA4=2, NAPOT=3.
REQ-022 In each write state, wr_valid_o SHALL be 1 and wr_* SHALL stay stable until wr_ready_i; the FSM advances on the cycle where wr_valid_o && wr_ready_i.
REQ-023 RESP SHALL last exactly one cycle with rsp_valid_o=1, then return to IDLE; rsp_err_o=0 on success.
REQ-024 With wr_ready_i held at 1, a NAPOT request SHALL complete in 5 cycles from acceptance to the rsp_valid_o cycle, inclusive (CHECK, 3 writes, RESP).
REQ-025 locked_i SHALL be sampled only in CHECK; later changes SHALL NOT abort the sequence.

Reset
REQ-026 While rst_i=1 at a clk_i edge, the FSM SHALL return to IDLE and all outputs SHALL reset: req_ready_o=0 during reset, wr_valid_o=0, rsp_valid_o=0, rsp_err_o=0, wr_data_o=0, wr_idx_o=0, wr_is_cfg_o=0.
REQ-027 A reset asserted mid-sequence SHALL abandon the request with no response; already-completed writes stand.

Structure
REQ-028 pmp_addr_mode_t (OFF/TOR/NA4/NAPOT) and the cfg-byte layout SHALL be taken from the shared riscv package; a new pmpcfg_t packed struct SHALL be added there.
REQ-029 The pure-combinational encode/check logic SHALL live in one sub-module, pmp_region_encode (inputs: base, size, idx, locked; outputs: mode, addr, addr_prev, err).

Verification
REQ-030 The bench SHALL cover: base=0x8000_0000, size=12, idx=1, perm=3'b011 -> writes cfg1=0x00, addr1=0x2000_01FF, cfg1=0x1B; rsp_err_o=0.
REQ-031 The bench SHALL cover: base=0x1000, size=2, idx=0, perm=3'b001, lock=1 -> writes cfg0=0x00, addr0=0x400, cfg0=0x91.
REQ-032 The bench SHALL cover: base=0x1100, size=12, idx=3, perm=3'b111 -> writes cfg3=0, cfg2=0, addr2=0x440, addr3=0x840, cfg3=0x0F.
REQ-033 The bench SHALL cover: locked_i[5]=1, idx=5 (and separately TOR at idx=0) -> no wr_valid_o, rsp_valid_o=1, rsp_err_o=1.
REQ-034 The bench SHALL cover: wr_ready_i held low for 7 cycles in ADDR -> wr_data_o/wr_idx_o constant, req_ready_o=0, the sequence resumes in order.
REQ-035 The bench SHALL cover: rst_i asserted during ADDR_PREV -> the next cycle shows IDLE outputs and no rsp_valid_o, and a new request is accepted normally.
